// File: rtl/seq_transmitter.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first with
// a repeat count, an optional idle gap between repetitions, and start/busy/done/err handshaking.
module seq_transmitter #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [REP_W-1:0]   i_repeat,
  input  logic [GAP_W-1:0]   i_gap,
  output logic               o_out,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int BIT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [REP_W-1:0]   r_rep;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [BIT_W-1:0]   r_bit;
  logic               r_done;
  logic               r_err;

  logic w_len_ok, w_accept, w_reject, w_last_bit, w_reps_left, w_gap_end;

  assign w_len_ok    = (i_len != '0) && (i_len <= LEN_W'(MAX_LEN));
  assign w_accept    = (r_state == S_IDLE) && i_start && w_len_ok;
  assign w_reject    = (r_state == S_IDLE) && i_start && !w_len_ok;
  assign w_last_bit  = (r_bit == '0);
  assign w_reps_left = (r_rep != '0);
  assign w_gap_end   = (r_gap_cnt == '0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: default assignment first so no path through the comb block infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_last_bit) begin
          if (!w_reps_left)     w_next = S_IDLE;
          else if (r_gap != '0) w_next = S_GAP;
        end
      end
      S_GAP:   if (w_gap_end) w_next = S_SHIFT;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latched request, bit/repeat/gap counters and the registered pulses.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_rep     <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_bit     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_reject;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pattern <= i_pattern;
            r_len     <= i_len;
            r_rep     <= i_repeat;
            r_gap     <= i_gap;
            r_bit     <= BIT_W'(i_len - LEN_ONE);
          end
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            if (w_reps_left) begin
              // Reload for the next repetition; the gap counter is ignored when gap is 0.
              r_rep     <= r_rep - REP_ONE;
              r_bit     <= BIT_W'(r_len - LEN_ONE);
              r_gap_cnt <= r_gap - GAP_ONE;
            end else begin
              r_done <= 1'b1;
            end
          end else begin
            r_bit <= r_bit - BIT_ONE;
          end
        end
        S_GAP: begin
          if (!w_gap_end) r_gap_cnt <= r_gap_cnt - GAP_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_out   = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (r_state)
      S_SHIFT: begin
        o_out   = r_pattern[r_bit];
        o_valid = 1'b1;
        o_busy  = 1'b1;
      end
      S_GAP:   o_busy = 1'b1;
      default: ;
    endcase
  end

  assign o_done = r_done;
  assign o_err  = r_err;

endmodule

// File: tb/tb_seq_transmitter.sv
// Table-driven bench for seq_transmitter: each row drives one cycle of inputs
// and gives the {out,valid,busy,done,err} expected just after that clock edge.
module tb_seq_transmitter;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_pattern = '0;
  logic [3:0] i_len = '0;
  logic [3:0] i_repeat = '0;
  logic [3:0] i_gap = '0;
  logic       o_out, o_valid, o_busy, o_done, o_err;

  int checks = 0;
  int failures = 0;

  seq_transmitter #(.MAX_LEN(8), .LEN_W(4), .REP_W(4), .GAP_W(4)) dut (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_pattern(i_pattern),
    .i_len    (i_len),
    .i_repeat (i_repeat),
    .i_gap    (i_gap),
    .o_out    (o_out),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] pat;
    logic [3:0] len;
    logic [3:0] rep;
    logic [3:0] gap;
    logic [4:0] exp;  // {out, valid, busy, done, err}
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic add(input logic rst, input logic start, input logic [7:0] pat,
                     input logic [3:0] len, input logic [3:0] rep, input logic [3:0] gap,
                     input logic [4:0] exp);
    vec_t v;
    v.rst = rst; v.start = start; v.pat = pat; v.len = len; v.rep = rep; v.gap = gap; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Idle row: no reset, no start, inputs zero.
  task automatic idle(input logic [4:0] exp);
    add(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, exp);
  endtask

  localparam logic [4:0] Z  = 5'b00000;  // all low
  localparam logic [4:0] B1 = 5'b11100;  // bit 1 on the line
  localparam logic [4:0] B0 = 5'b01100;  // bit 0 on the line
  localparam logic [4:0] GP = 5'b00100;  // gap cycle
  localparam logic [4:0] DN = 5'b00010;  // done pulse
  localparam logic [4:0] ER = 5'b00001;  // err pulse

  function automatic logic [4:0] outs();
    return {o_out, o_valid, o_busy, o_done, o_err};
  endfunction

  logic [11:0] seq_out;
  logic [11:0] seq_valid;
  int          busy_cycles;

  initial begin
    // Test 1: reset, then 10101 single transmission.
    add(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, Z);
    add(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, Z);
    idle(Z);
    add(1'b0, 1'b1, 8'h15, 4'd5, 4'd0, 4'd0, B1);
    idle(B0); idle(B1); idle(B0); idle(B1);
    idle(DN);
    idle(Z);
    // Test 3: 101 sent three times back to back.
    add(1'b0, 1'b1, 8'h05, 4'd3, 4'd2, 4'd0, B1);
    idle(B0); idle(B1); idle(B1); idle(B0); idle(B1); idle(B1); idle(B0); idle(B1);
    idle(DN);
    idle(Z);
    // Test 4: illegal lengths rejected, then a legal start.
    add(1'b0, 1'b1, 8'hFF, 4'd0, 4'd0, 4'd0, ER);
    idle(Z);
    add(1'b0, 1'b1, 8'hFF, 4'd9, 4'd0, 4'd0, ER);
    idle(Z);
    add(1'b0, 1'b1, 8'h02, 4'd2, 4'd0, 4'd0, B1);
    idle(B0);
    idle(DN);
    idle(Z);
    // Test 5: starts while busy ignored; start in the done cycle accepted.
    add(1'b0, 1'b1, 8'h15, 4'd5, 4'd0, 4'd0, B1);
    add(1'b0, 1'b1, 8'hFF, 4'd0, 4'd3, 4'd1, B0);
    add(1'b0, 1'b1, 8'h00, 4'd3, 4'd0, 4'd0, B1);
    idle(B0); idle(B1);
    idle(DN);
    add(1'b0, 1'b1, 8'h06, 4'd3, 4'd0, 4'd0, B1);
    idle(B1); idle(B0);
    idle(DN);
    idle(Z);
    // Test 6: reset during bit 3 abandons the transfer; next transfer is clean.
    add(1'b0, 1'b1, 8'h15, 4'd5, 4'd0, 4'd0, B1);
    idle(B0); idle(B1);
    add(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, Z);
    idle(Z); idle(Z);
    add(1'b0, 1'b1, 8'h2D, 4'd6, 4'd0, 4'd0, B1);
    idle(B0); idle(B1); idle(B1); idle(B0); idle(B1);
    idle(DN);
    // Reset wins over a simultaneous start.
    add(1'b1, 1'b1, 8'hFF, 4'd4, 4'd0, 4'd0, Z);
    idle(Z);

    foreach (vecs[i]) begin
      @(negedge clk);
      i_reset   = vecs[i].rst;
      i_start   = vecs[i].start;
      i_pattern = vecs[i].pat;
      i_len     = vecs[i].len;
      i_repeat  = vecs[i].rep;
      i_gap     = vecs[i].gap;
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Test 2: two repetitions separated by a two-cycle gap.
    seq_out     = 12'b1010_1001_0101;
    seq_valid   = 12'b1111_1001_1111;
    busy_cycles = 0;
    @(negedge clk);
    i_reset   = 1'b0;
    i_start   = 1'b1;
    i_pattern = 8'h15;
    i_len     = 4'd5;
    i_repeat  = 4'd1;
    i_gap     = 4'd2;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("gap_seq%0d", i), 32'(outs()),
            32'({seq_out[11-i], seq_valid[11-i], 1'b1, 1'b0, 1'b0}));
      if (o_busy) busy_cycles++;
      @(negedge clk);
      i_start   = 1'b0;
      i_pattern = 8'h00;
    end
    @(posedge clk);
    #1;
    check("gap_seq_done", 32'(outs()), 32'(DN));
    check("gap_seq_busy_cycles", 32'(busy_cycles), 32'd12);
    @(posedge clk);
    #1;
    check("gap_seq_idle", 32'(outs()), 32'(Z));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_transmitter.md
Name: seq_transmitter

Overview:
Serial bit-pattern transmitter. It is the driving end of the single-bit serial line that the sequence recognizer samples.
- Shifts a programmable pattern out on one wire, one bit per clock, MSB-first.
- Supports a repeat count and an idle gap between repetitions.
- Provides a start/busy/done handshake so a controller or bench can drive recognizer stimulus without hand-written delays.

Parameters:
- MAX_LEN, 8, width of pattern input and maximum bits per repetition
- LEN_W, 4, width of len input; must encode MAX_LEN
- REP_W, 4, width of repeat input
- GAP_W, 4, width of gap input

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when idle
- pattern  input  MAX_LEN  pattern bits; transmits pattern[len-1] down to pattern[0]
- len  input  LEN_W  bits per repetition; legal range 1..MAX_LEN
- repeat  input  REP_W  extra repetitions; total transmissions = repeat+1
- gap  input  GAP_W  idle cycles between repetitions; out=0 during the gap
- out  output  1  serial data line
- valid  output  1  high when out carries a pattern bit
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the final bit
- err  output  1  one-cycle pulse when a start is rejected

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high.
- While reset=1 at a clk edge, all outputs go to 0 and the FSM returns to IDLE. Reset wins over start in the same cycle.
- Reset mid-transfer: the transfer is abandoned, no done pulse is issued, and latched pattern state is cleared.
- FSM states:
  - IDLE
  - SHIFT
  - GAP
- Start acceptance:
  - In IDLE, start=1 with 1<=len<=MAX_LEN latches pattern, len, repeat and gap, then enters SHIFT.
  - Bit pattern[len-1] appears on out in the cycle after the start cycle (latency 1).
- Start rejection:
  - In IDLE, start=1 with len=0 or len>MAX_LEN leaves the FSM in IDLE.
  - err=1 for the single following cycle; busy, valid and out stay 0.
- SHIFT state:
  - Each cycle drives the next bit, with valid=1 and busy=1.
  - A bit counter runs from len-1 down to 0.
- After the last bit of a repetition:
  - If repetitions remain and gap>0: enter GAP for exactly gap cycles (out=0, valid=0, busy=1), then return to SHIFT with the counter reloaded to len-1.
  - If repetitions remain and gap=0: the next repetition's first bit follows in the very next cycle, with no bubble.
  - If none remain: go to IDLE. done=1 and busy=0 in the next cycle.
- The repetition counter is loaded with repeat and decremented at the end of each repetition. repeat=0 means a single transmission.
- A start arriving while busy=1 is ignored: no err, and the latched inputs are unchanged.
- Back-to-back transfers: start in the done cycle is accepted, because the FSM is already in IDLE. The first new bit follows in the next cycle.
- Pattern input changes after acceptance have no effect on the transfer in progress.
- In IDLE, out=0 and valid=0.
- done and err are registered single-cycle pulses and are never high together.
- Total busy cycles per transfer = (repeat+1)*len + repeat*gap.

Test Plan:
1. Reset 2 cycles, then start with pattern=8'h15, len=5, repeat=0, gap=0 -> out=1,0,1,0,1 on cycles 1-5 after start; valid=1 and busy=1 for those 5 cycles; done=1 on cycle 6.
2. pattern=8'h15, len=5, repeat=1, gap=2 -> out stream 1,0,1,0,1,0,0,1,0,1,0,1; valid low only on the two gap cycles; busy held for 12 cycles; done on cycle 13.
3. pattern=8'h05, len=3, repeat=2, gap=0 -> contiguous 1,0,1,1,0,1,1,0,1 with valid high for 9 cycles; done on cycle 10.
4. start with len=0, then with len=9 -> err pulse one cycle after each start; busy, valid and out stay 0; a following legal start works normally.
5. start pulsed mid-transfer with different pattern/len -> ignored, original stream unchanged; a start in the done cycle begins the new stream on the next cycle with no gap.
6. reset=1 during bit 3 of a 5-bit transfer -> next cycle out, valid, busy, done and err are all 0; no done pulse; a subsequent start transmits the full new pattern correctly.
